// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;
  localparam int REG_COUNT_DEF = 32;
  localparam int REG_BITS_DEF  = $clog2(REG_COUNT_DEF);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX operand forwarding select for one source operand; EX/MEM wins over MEM/WB, x0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic [REG_BITS-1:0] ex_rs_i,
  input  logic [REG_BITS-1:0] em_rd_i,
  input  logic                em_reg_write_i,
  input  logic [REG_BITS-1:0] mw_rd_i,
  input  logic                mw_reg_write_i,
  output logic [1:0]          fwd_o
);
  always_comb begin
    fwd_o = FWD_RF;
    if (em_reg_write_i && (em_rd_i != '0) && (em_rd_i == ex_rs_i))
      fwd_o = FWD_EM;
    else if (mw_reg_write_i && (mw_rd_i != '0) && (mw_rd_i == ex_rs_i))
      fwd_o = FWD_MW;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control: load-use interlock, branch flush, memory wait, multi-cycle EX
// sequencing, operand forwarding selects and stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int REG_BITS  = $clog2(REG_COUNT),
  parameter int MUL_LAT   = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_BITS-1:0]  dec_rs1,
  input  logic [REG_BITS-1:0]  dec_rs2,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic [REG_BITS-1:0]  ex_rs1,
  input  logic [REG_BITS-1:0]  ex_rs2,
  input  logic [REG_BITS-1:0]  ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_multi,
  input  logic                 branch_taken,
  input  logic [REG_BITS-1:0]  em_rd,
  input  logic [REG_BITS-1:0]  mw_rd,
  input  logic                 em_reg_write,
  input  logic                 mw_reg_write,
  input  logic                 mem_busy,
  input  logic                 cnt_clr,
  output logic                 pc_en,
  output logic                 fd_en,
  output logic                 de_en,
  output logic                 em_en,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic                 em_flush,
  output logic                 mul_start,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);
  localparam int WCNT_W = $clog2(MUL_LAT) + 1;

  state_e               state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 branch_flush;
  logic                 load_use;
  logic [1:0]           fwd_a_raw, fwd_b_raw;

  fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
    .ex_rs_i        (ex_rs1),
    .em_rd_i        (em_rd),
    .em_reg_write_i (em_reg_write),
    .mw_rd_i        (mw_rd),
    .mw_reg_write_i (mw_reg_write),
    .fwd_o          (fwd_a_raw)
  );

  fwd_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
    .ex_rs_i        (ex_rs2),
    .em_rd_i        (em_rd),
    .em_reg_write_i (em_reg_write),
    .mw_rd_i        (mw_rd),
    .mw_reg_write_i (mw_reg_write),
    .fwd_o          (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((dec_use_rs1 && (dec_rs1 == ex_rd)) ||
                     (dec_use_rs2 && (dec_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pc_en        = 1'b0;
    fd_en        = 1'b0;
    de_en        = 1'b0;
    em_en        = 1'b0;
    fd_flush     = 1'b0;
    de_flush     = 1'b0;
    em_flush     = 1'b0;
    mul_start    = 1'b0;
    branch_flush = 1'b0;
    if (rst || mem_busy) begin
      // everything frozen; state and wcnt hold
    end else if ((state_q == ST_RUN) && ex_multi) begin
      mul_start = 1'b1;
      em_en     = 1'b1;
      em_flush  = 1'b1;
      wcnt_d    = WCNT_W'(MUL_LAT - 1);
      state_d   = ST_MUL_WAIT;
    end else if ((state_q == ST_MUL_WAIT) && (wcnt_q > WCNT_W'(1))) begin
      em_en    = 1'b1;
      em_flush = 1'b1;
      wcnt_d   = wcnt_q - WCNT_W'(1);
    end else begin
      // RUN, or the release cycle of MUL_WAIT (ex_multi not re-examined)
      if (state_q == ST_MUL_WAIT) begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
      if (branch_taken) begin
        branch_flush = 1'b1;
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        de_en        = 1'b1;
        em_en        = 1'b1;
        fd_flush     = 1'b1;
        de_flush     = 1'b1;
      end else if (load_use) begin
        de_en    = 1'b1;
        de_flush = 1'b1;
        em_en    = 1'b1;
      end else begin
        pc_en = 1'b1;
        fd_en = 1'b1;
        de_en = 1'b1;
        em_en = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (branch_flush && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
        flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MUL_LAT=4, 4-bit counters to reach saturation quickly).
module tb_hazard_ctrl;
  localparam int RB = 5;
  localparam logic [7:0] NRM = 8'b1111_0000;
  localparam logic [7:0] LU  = 8'b0011_0100;
  localparam logic [7:0] BR  = 8'b1111_1100;
  localparam logic [7:0] MS  = 8'b0001_0011;
  localparam logic [7:0] FZ  = 8'b0001_0010;
  localparam logic [7:0] ZZ  = 8'b0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RB-1:0] dec_rs1 = '0, dec_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
  logic [RB-1:0] em_rd = '0, mw_rd = '0;
  logic          dec_use_rs1 = 0, dec_use_rs2 = 0, ex_is_load = 0, ex_multi = 0;
  logic          branch_taken = 0, em_reg_write = 0, mw_reg_write = 0;
  logic          mem_busy = 0, cnt_clr = 0;
  logic          pc_en, fd_en, de_en, em_en, fd_flush, de_flush, em_flush, mul_start;
  logic [1:0]    fwd_a, fwd_b;
  logic [3:0]    stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [11:0] ctrl;
    logic [3:0]  st;
    logic [3:0]  fl;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_st = '0;
  logic [3:0] m_fl = '0;

  hazard_ctrl #(.MUL_LAT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_multi(ex_multi), .branch_taken(branch_taken),
    .em_rd(em_rd), .mw_rd(mw_rd),
    .em_reg_write(em_reg_write), .mw_reg_write(mw_reg_write),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
    .mul_start(mul_start), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after a negedge; outputs settle and are compared 2ns later.
  task automatic cyc(input string tag, input logic [7:0] ctl,
                     input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00);
    exp_t e;
    if (rst) begin
      m_st = '0;
      m_fl = '0;
    end
    sb.push_back('{tag, {ctl, fa, fb}, m_st, m_fl});
    #2;
    e = sb.pop_front();
    chk({e.tag, "_ctrl"},
        {pc_en, fd_en, de_en, em_en, fd_flush, de_flush, em_flush, mul_start, fwd_a, fwd_b},
        e.ctrl);
    chk({e.tag, "_stall"}, {8'h0, stall_cnt}, {8'h0, e.st});
    chk({e.tag, "_flush"}, {8'h0, flush_cnt}, {8'h0, e.fl});
    if (cnt_clr) begin
      m_st = '0;
      m_fl = '0;
    end else if (!rst) begin
      if (!ctl[7] && m_st != 4'hF) m_st++;
      if (ctl == BR && m_fl != 4'hF) m_fl++;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cyc("reset", ZZ);
    rst = 0;

    ex_is_load = 1; ex_rd = 5; dec_rs1 = 5; dec_use_rs1 = 1;
    cyc("loaduse", LU);
    ex_is_load = 0;
    cyc("loaduse_after", NRM);

    ex_is_load = 1; ex_rd = 0; dec_rs1 = 0; dec_use_rs1 = 1;
    cyc("x0_load", NRM);
    ex_rd = 7; dec_rs2 = 7; dec_use_rs2 = 0; dec_use_rs1 = 0;
    cyc("unused_rs2", NRM);
    ex_is_load = 0; em_rd = 0; em_reg_write = 1; ex_rs1 = 0;
    cyc("x0_fwd", NRM, 2'b00, 2'b00);

    em_rd = 3; mw_rd = 3; em_reg_write = 1; mw_reg_write = 1; ex_rs1 = 3; ex_rs2 = 0;
    cyc("fwd_em_prio", NRM, 2'b01, 2'b00);
    ex_rs2 = 3;
    cyc("fwd_b_em", NRM, 2'b01, 2'b01);
    em_reg_write = 0; ex_rs2 = 9;
    cyc("fwd_mw", NRM, 2'b10, 2'b00);
    mw_reg_write = 0; ex_rs1 = 0; ex_rs2 = 0;

    branch_taken = 1; ex_is_load = 1; ex_rd = 5; dec_rs1 = 5; dec_use_rs1 = 1;
    cyc("branch_lu", BR);
    branch_taken = 0; ex_is_load = 0;
    cyc("branch_after", NRM);

    ex_multi = 1;
    cyc("mul0", MS);
    branch_taken = 1;
    cyc("mul1_br_ignored", FZ);
    branch_taken = 0;
    cyc("mul2", FZ);
    cyc("mul3_release", NRM);
    ex_multi = 0;
    cyc("mul_after", NRM);

    ex_multi = 1;
    cyc("mulb0", MS);
    mem_busy = 1;
    cyc("mulb_busy1", ZZ);
    cyc("mulb_busy2", ZZ);
    mem_busy = 0;
    cyc("mulb3", FZ);
    cyc("mulb4", FZ);
    branch_taken = 1;
    cyc("mulb5_release_br", BR);
    ex_multi = 0; branch_taken = 0;
    cyc("mulb_after", NRM);

    ex_multi = 1;
    cyc("mulr0", MS);
    rst = 1;
    cyc("mulr_reset", ZZ);
    rst = 0;
    cyc("mulr_restart", MS);
    cyc("mulr1", FZ);
    cyc("mulr2", FZ);
    cyc("mulr3", NRM);
    ex_multi = 0;

    mem_busy = 1;
    for (int i = 0; i < 18; i++) cyc("sat_stall", ZZ);
    mem_busy = 0; branch_taken = 1;
    for (int i = 0; i < 18; i++) cyc("sat_flush", BR);
    branch_taken = 0; mem_busy = 1; cnt_clr = 1;
    cyc("clr_prio", ZZ);
    cnt_clr = 0; mem_busy = 0;
    cyc("clr_after", NRM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
